stopwatch_ctrl: RTL and testbench

Control stage directly upstream of the 3-digit BCD counter. It debounces three raw push-buttons (start/stop, clear, load) and runs a run/pause/done state machine. It generates the counter's one-cycle count-enable tick from a clock prescaler, and its clear and load pulses. It consumes the counter's terminal flag `cnt_9` to halt counting at 999.

---
 rtl/stopwatch_ctrl_if.sv | 20 ++
 rtl/stopwatch_ctrl.sv | 133 +++++++++++++
 tb/tb_stopwatch_ctrl.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/stopwatch_ctrl_if.sv
// stopwatch_ctrl_if: button, terminal-flag and counter-control signals of the stopwatch control stage
interface stopwatch_ctrl_if;
  logic btn_start;
  logic btn_clear;
  logic btn_load;
  logic cnt_9;
  logic enb;
  logic clr;
  logic ld;
  logic [1:0] state;
  logic running;
  modport master (
    output btn_start, btn_clear, btn_load, cnt_9,
    input  enb, clr, ld, state, running
  );
  modport slave (
    input  btn_start, btn_clear, btn_load, cnt_9,
    output enb, clr, ld, state, running
  );
endinterface

// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: debounced run/pause/done control for a 3-digit BCD counter (AUTO_RESTART_EN: wrap 999->000 and keep running)
module stopwatch_ctrl #(
  parameter int CLK_DIV    = 50000,
  parameter int DEB_CYCLES = 1000
) (
  input logic ck,
  input logic rst_s,
  stopwatch_ctrl_if.slave bus
);
  localparam int DW = $clog2(DEB_CYCLES + 1);
  localparam int PW = $clog2(CLK_DIV);
  localparam logic [1:0] IDLE  = 2'b00;
  localparam logic [1:0] RUN   = 2'b01;
  localparam logic [1:0] PAUSE = 2'b10;
  localparam logic [1:0] DONE  = 2'b11;
  logic [2:0] raw, s1, s2, deb, deb_d, press;
  logic ev_clr, ev_st, ev_ld;
  logic [1:0] st, nst;
  logic [PW-1:0] pre, npre;
  logic wrap;
  logic enb, clr, ld, run_q;
  logic n_enb, n_clr, n_ld;
  // bit 0 start, bit 1 clear, bit 2 load
  assign raw = {bus.btn_load, bus.btn_clear, bus.btn_start};
  // two-flop synchronizers for the asynchronous buttons
  always_ff @(posedge ck)
    if (rst_s) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= raw;
      s2 <= s1;
    end
  for (genvar i = 0; i < 3; i++) begin : g_deb
    logic [DW-1:0] cnt;
    logic lvl;
    // accept a new level only after DEB_CYCLES consecutive differing samples; any bounce restarts
    always_ff @(posedge ck)
      if (rst_s) begin
        cnt <= '0;
        lvl <= 1'b0;
      end else if (s2[i] == lvl) begin
        cnt <= '0;
      end else if (cnt == DW'(DEB_CYCLES - 1)) begin
        cnt <= '0;
        lvl <= s2[i];
      end else begin
        cnt <= cnt + 1'b1;
      end
    assign deb[i] = lvl;
  end
  // previous debounced levels for rising-edge detection
  always_ff @(posedge ck)
    if (rst_s) deb_d <= '0;
    else deb_d <= deb;
  assign press  = deb & ~deb_d;
  assign ev_clr = press[1];
  assign ev_st  = press[0] & ~press[1];
  assign ev_ld  = press[2] & ~press[1] & ~press[0];
  assign wrap   = (st == RUN) && (pre == PW'(CLK_DIV - 1));
  // next state, prescaler and output pulses
  always_comb begin
    nst   = st;
    npre  = pre;
    n_enb = 1'b0;
    n_clr = 1'b0;
    n_ld  = 1'b0;
    case (st)
      IDLE: begin
        if (ev_clr) n_clr = 1'b1;
        else if (ev_st) begin
          nst  = RUN;
          npre = '0;
        end else if (ev_ld) n_ld = 1'b1;
      end
      RUN: begin
        npre = wrap ? '0 : pre + 1'b1;
        if (ev_clr) begin
          n_clr = 1'b1;
          nst   = IDLE;
          npre  = '0;
        end else if (wrap && bus.cnt_9) nst = DONE;
        else begin
          n_enb = wrap;
          nst   = ev_st ? PAUSE : RUN;
        end
      end
      PAUSE: begin
        if (ev_clr) begin
          n_clr = 1'b1;
          nst   = IDLE;
          npre  = '0;
        end else if (ev_st) nst = RUN;
        else if (ev_ld) n_ld = 1'b1;
      end
      DONE: begin
`ifdef AUTO_RESTART_EN
        n_clr = 1'b1;
        nst   = ev_clr ? IDLE : RUN;
        npre  = '0;
`else
        if (ev_clr) begin
          n_clr = 1'b1;
          nst   = IDLE;
          npre  = '0;
        end
`endif
      end
    endcase
  end
  // registered state and outputs
  always_ff @(posedge ck)
    if (rst_s) begin
      st    <= IDLE;
      pre   <= '0;
      enb   <= 1'b0;
      clr   <= 1'b0;
      ld    <= 1'b0;
      run_q <= 1'b0;
    end else begin
      st    <= nst;
      pre   <= npre;
      enb   <= n_enb;
      clr   <= n_clr;
      ld    <= n_ld;
      run_q <= (nst == RUN);
    end
  assign bus.enb     = enb;
  assign bus.clr     = clr;
  assign bus.ld      = ld;
  assign bus.state   = st;
  assign bus.running = run_q;
endmodule

// File: tb/tb_stopwatch_ctrl.sv
// tb_stopwatch_ctrl: table, hand-sequence and randomized checks of stopwatch_ctrl against a reference model
module tb_stopwatch_ctrl;
  localparam int CD = 4;
  localparam int DB = 3;
  localparam logic [1:0] IDLE = 2'b00, RUN = 2'b01, PAUSE = 2'b10, DONE = 2'b11;
`ifdef AUTO_RESTART_EN
  localparam bit AR = 1'b1;
`else
  localparam bit AR = 1'b0;
`endif
  logic ck = 1'b0;
  logic rst_s = 1'b1;
  int checks = 0;
  int errors = 0;
  stopwatch_ctrl_if bus();
  stopwatch_ctrl #(.CLK_DIV(CD), .DEB_CYCLES(DB)) dut (.ck(ck), .rst_s(rst_s), .bus(bus.slave));
  always #5 ck = ~ck;
  typedef struct {
    logic s, c, l, n9;
    int cyc;
    logic [1:0] st;
    bit chk;
  } vec_t;
  vec_t tbl[$];
  logic [1:0] ms;
  int mph;
  logic [2:0] lvl, lvl_d;
  logic [2:0] hq[$];
  logic e_enb, e_clr, e_ld;
  function automatic void model_reset();
    ms = IDLE;
    mph = 0;
    lvl = '0;
    lvl_d = '0;
    e_enb = 0;
    e_clr = 0;
    e_ld = 0;
    hq.delete();
    for (int k = 0; k < DB + 2; k++) hq.push_back(3'b000);
  endfunction
  function automatic void model_step(logic r, logic [2:0] raw, logic n9);
    logic [2:0] ev;
    logic tick;
    bit diff;
    if (r) begin
      model_reset();
      return;
    end
    ev = lvl & ~lvl_d;
    tick = (ms == RUN) && (mph % CD == CD - 1);
    if (ms == RUN) mph++;
    e_enb = 0;
    e_clr = 0;
    e_ld = 0;
    case (ms)
      IDLE: if (ev[1]) e_clr = 1; else if (ev[0]) begin ms = RUN; mph = 0; end else if (ev[2]) e_ld = 1;
      RUN: if (ev[1]) begin e_clr = 1; ms = IDLE; mph = 0; end
           else if (tick && n9) begin ms = DONE; mph = 0; end
           else begin e_enb = tick; if (ev[0]) ms = PAUSE; end
      PAUSE: if (ev[1]) begin e_clr = 1; ms = IDLE; mph = 0; end else if (ev[0]) ms = RUN; else if (ev[2]) e_ld = 1;
      DONE: if (AR) begin e_clr = 1; ms = ev[1] ? IDLE : RUN; mph = 0; end
            else if (ev[1]) begin e_clr = 1; ms = IDLE; mph = 0; end
    endcase
    lvl_d = lvl;
    hq.push_back(raw);
    void'(hq.pop_front());
    for (int b = 0; b < 3; b++) begin
      diff = 1;
      for (int j = 0; j < DB; j++) if (hq[hq.size() - 3 - j][b] == lvl[b]) diff = 0;
      if (diff) lvl[b] = ~lvl[b];
    end
  endfunction
  task automatic chk(string nm, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask
  task automatic step();
    @(posedge ck);
    model_step(rst_s, {bus.btn_load, bus.btn_clear, bus.btn_start}, bus.cnt_9);
    #1;
    chk("enb", bus.enb, e_enb);
    chk("clr", bus.clr, e_clr);
    chk("ld", bus.ld, e_ld);
    chk("state", bus.state, ms);
    chk("running", bus.running, ms == RUN);
  endtask
  task automatic set_in(logic s, logic c, logic l, logic n9);
    bus.btn_start = s;
    bus.btn_clear = c;
    bus.btn_load = l;
    bus.cnt_9 = n9;
  endtask
  function automatic void add(logic s, logic c, logic l, logic n9, int cyc, logic [1:0] st, bit chk_en);
    tbl.push_back('{s, c, l, n9, cyc, st, chk_en});
  endfunction
  initial begin
    int n;
    bit saw;
    int rem[3];
    logic [2:0] lv;
    add(0, 0, 0, 0, 4, IDLE, 1);
    add(1, 0, 0, 0, 2, IDLE, 1);
    add(0, 0, 0, 0, 6, IDLE, 1);
    add(1, 0, 0, 0, 10, RUN, 1);
    add(0, 0, 0, 0, 8, RUN, 1);
    add(1, 0, 0, 0, 8, PAUSE, 1);
    add(0, 0, 0, 0, 8, PAUSE, 1);
    add(0, 0, 1, 0, 8, PAUSE, 1);
    add(0, 0, 0, 0, 8, PAUSE, 1);
    add(1, 1, 0, 0, 8, IDLE, 1);
    add(0, 0, 0, 0, 8, IDLE, 1);
    add(0, 0, 1, 0, 8, IDLE, 1);
    add(0, 0, 0, 0, 8, IDLE, 1);
    add(1, 0, 0, 0, 8, RUN, 1);
    add(0, 0, 1, 0, 8, RUN, 1);
    add(0, 0, 0, 1, 8, DONE, !AR);
    add(0, 0, 0, 0, 8, DONE, !AR);
    add(1, 0, 0, 0, 8, DONE, !AR);
    add(0, 0, 0, 0, 8, DONE, !AR);
    add(0, 1, 0, 0, 8, IDLE, 1);
    add(0, 0, 0, 0, 8, IDLE, 1);
    set_in(0, 0, 0, 0);
    rst_s = 1;
    model_reset();
    step();
    step();
    chk("rst_state", bus.state, IDLE);
    chk("rst_enb", bus.enb, 0);
    chk("rst_clr", bus.clr, 0);
    chk("rst_ld", bus.ld, 0);
    chk("rst_running", bus.running, 0);
    rst_s = 0;
    step();
    set_in(1, 0, 0, 0);
    n = 0;
    do begin step(); n++; end while (bus.state != RUN && n < 20);
    chk("start_latency", n, DB + 3);
    chk("running_after_start", bus.running, 1);
    bus.btn_start = 0;
    for (int t = 0; t < 3; t++) begin
      n = 0;
      do begin step(); n++; end while (!bus.enb && n < 20);
      chk("tick_interval", n, CD);
    end
    rst_s = 1;
    step();
    chk("midrun_rst_state", bus.state, IDLE);
    chk("midrun_rst_running", bus.running, 0);
    rst_s = 0;
    repeat (8) step();
    foreach (tbl[k]) begin
      set_in(tbl[k].s, tbl[k].c, tbl[k].l, tbl[k].n9);
      repeat (tbl[k].cyc) step();
      if (tbl[k].chk) begin
        chk($sformatf("tbl%0d_state", k), bus.state, tbl[k].st);
        chk($sformatf("tbl%0d_running", k), bus.running, tbl[k].st == RUN);
      end
    end
    set_in(1, 0, 0, 0);
    n = 0;
    do begin step(); n++; end while (bus.state != RUN && n < 20);
    chk("reenter_run", bus.state, RUN);
    set_in(0, 0, 0, 1);
    n = 0;
    do begin step(); n++; end while (bus.state != DONE && n < 20);
    chk("reach_done", bus.state, DONE);
    bus.cnt_9 = 0;
`ifdef AUTO_RESTART_EN
    step();
    chk("auto_clr", bus.clr, 1);
    chk("auto_state", bus.state, RUN);
    n = 0;
    do begin step(); n++; end while (!bus.enb && n < 20);
    chk("auto_first_tick", n, CD);
    set_in(0, 1, 0, 0);
`else
    bus.btn_start = 1;
    repeat (8) step();
    bus.btn_start = 0;
    repeat (8) step();
    chk("done_holds", bus.state, DONE);
    bus.btn_clear = 1;
`endif
    saw = 0;
    n = 0;
    do begin step(); n++; saw |= bus.clr; end while (bus.state != IDLE && n < 20);
    chk("clear_pulse", saw, 1);
    chk("clear_to_idle", bus.state, IDLE);
    bus.btn_clear = 0;
    repeat (8) step();
    lv = '0;
    foreach (rem[b]) rem[b] = $urandom_range(1, 12);
    for (int t = 0; t < 3000; t++) begin
      for (int b = 0; b < 3; b++) begin
        rem[b]--;
        if (rem[b] == 0) begin
          lv[b] = ~lv[b];
          rem[b] = $urandom_range(1, 12);
        end
      end
      set_in(lv[0], lv[1], lv[2], $urandom_range(0, 7) == 0);
      rst_s = ($urandom_range(0, 499) == 0);
      step();
    end
    rst_s = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
